// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, round counts, controller states and
// GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128 = 2'b00,
        MODE_192 = 2'b01,
        MODE_256 = 2'b10,
        MODE_ILL = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } ctrl_state_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] mode_to_nr(input aes_mode_e m);
        logic [3:0] nr;
        case (m)
            MODE_128: nr = NR_128;
            MODE_192: nr = NR_192;
            MODE_256: nr = NR_256;
            default:  nr = 4'd0;
        endcase
        return nr;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), a);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] inv_mix_coef(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = 8'h0e;
            2'd1:    c = 8'h0b;
            2'd2:    c = 8'h0d;
            default: c = 8'h09;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_inv_rounddata.sv
// One combinational AES inverse-cipher round; round 0 is the initial
// AddRoundKey, round Nr the final round without InvMixColumns.
module aes_inv_rounddata
    import aes_pkg::*;
(
    input  logic [3:0]   round_i,
    input  aes_mode_e    mode_i,
    input  logic [127:0] round_key_i,
    input  logic [127:0] data_in_i,
    output logic [127:0] data_out_o
);

    logic [127:0] sub_s;
    logic [127:0] ark_s;
    logic [127:0] mix_s;
    logic [3:0]   nr_s;

    // InvShiftRows then InvSubBytes: row r of column c is taken from column c-r
    always_comb begin
        sub_s = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_s[8*(15-(4*c+r)) +: 8] =
                    inv_sbox(data_in_i[8*(15-(4*((c-r+4)%4)+r)) +: 8]);
            end
        end
    end

    assign ark_s = sub_s ^ round_key_i;
    assign nr_s  = mode_to_nr(mode_i);

    // InvMixColumns of the key-mixed state
    always_comb begin
        mix_s = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc;
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(inv_mix_coef(2'(k - r + 4)),
                                       ark_s[8*(15-(4*c+k)) +: 8]);
                end
                mix_s[8*(15-(4*c+r)) +: 8] = acc;
            end
        end
    end

    // Round-type selection
    always_comb begin
        if (round_i == 4'd0) begin
            data_out_o = data_in_i ^ round_key_i;
        end else if (round_i == nr_s) begin
            data_out_o = ark_s;
        end else begin
            data_out_o = mix_s;
        end
    end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher controller (one round per clock, external key
// schedule). Optional block counter enabled by AES_INV_CTRL_BLKCNT_EN.
module aes_inv_round_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [1:0]   in_mode,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES_INV_CTRL_BLKCNT_EN
    output logic         out_err,
    output logic [31:0]  blk_cnt
`else
    output logic         out_err
`endif
);

    ctrl_state_e  state_q, state_d;
    aes_mode_e    mode_q, mode_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] data_q, data_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         out_err_q, out_err_d;
    logic [127:0] rd_out_s;
    logic [3:0]   nr_s;

    assign nr_s = mode_to_nr(mode_q);

    aes_inv_rounddata u_rounddata (
        .round_i     (round_q),
        .mode_i      (mode_q),
        .round_key_i (round_key),
        .data_in_i   (data_q),
        .data_out_o  (rd_out_s)
    );

    // Next-state and datapath control; flush aborts from any state
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        round_d     = round_q;
        data_d      = data_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        if (flush) begin
            state_d     = ST_IDLE;
            round_d     = 4'd0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_d  = aes_mode_e'(in_mode);
                        data_d  = in_data;
                        round_d = 4'd0;
                        if (aes_mode_e'(in_mode) == MODE_ILL) begin
                            state_d     = ST_DONE;
                            out_data_d  = 128'd0;
                            out_err_d   = 1'b1;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d   = ST_RUN;
                            out_err_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    data_d = rd_out_s;
                    if (round_q == nr_s) begin
                        state_d     = ST_DONE;
                        out_data_d  = rd_out_s;
                        out_valid_d = 1'b1;
                        round_d     = 4'd0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    round_d     = 4'd0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_128;
            round_q     <= 4'd0;
            data_q      <= 128'd0;
            out_data_q  <= 128'd0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            round_q     <= round_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign key_idx   = (state_q == ST_RUN) ? (nr_s - round_q) : 4'd0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

`ifdef AES_INV_CTRL_BLKCNT_EN
    logic [31:0] blk_cnt_q;

    // Completed-handshake counter, wraps naturally and survives flush
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= 32'd0;
        end else if (out_valid_q && out_ready && (state_q == ST_DONE)) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end else begin
            blk_cnt_q <= blk_cnt_q;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl with a behavioural key schedule and an
// expected-result queue; FIPS-197 vectors for all three key sizes.
module tb_aes_inv_round_ctrl;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [127:0] in_data, round_key, out_data;
    logic [1:0]   in_mode;
    logic [3:0]   key_idx;
`ifdef AES_INV_CTRL_BLKCNT_EN
    logic [31:0]  blk_cnt;
    int           exp_cnt = 0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] w [0:59];

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    aes_inv_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef AES_INV_CTRL_BLKCNT_EN
        .out_err   (out_err),
        .blk_cnt   (blk_cnt)
`else
        .out_err   (out_err)
`endif
    );

    // Key schedule model: serves the requested round key combinationally
    always_comb begin
        round_key = 128'd0;
        if (key_idx <= 4'd14) begin
            round_key = {w[4*int'(key_idx)], w[4*int'(key_idx)+1],
                         w[4*int'(key_idx)+2], w[4*int'(key_idx)+3]};
        end
    end

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        logic [7:0] r;
        r = a << 1;
        if (a[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, aa, bb;
        acc = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) acc = acc ^ aa;
            aa = m_xt(aa);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv, b;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            b = 8'(c);
            if (m_mul(x, b) == 8'h01) inv = b;
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] m_subword(input logic [31:0] v);
        return {m_sbox(v[31:24]), m_sbox(v[23:16]), m_sbox(v[15:8]), m_sbox(v[7:0])};
    endfunction

    task automatic expand_key(input logic [1:0] mode);
        int nk, nr;
        logic [31:0] t;
        logic [7:0]  rcon;
        nk = 4 + 2 * int'(mode);
        nr = nk + 6;
        for (int i = 0; i < nk; i++) begin
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        end
        rcon = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = m_subword({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = m_xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = m_subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] mode, input logic [127:0] ct);
        if (mode != 2'b11) expand_key(mode);
        in_valid = 1'b1;
        in_data  = ct;
        in_mode  = mode;
        chk("in_ready_idle", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_mode  = ~mode;
    endtask

    task automatic run_block(input logic [1:0] mode, input logic [127:0] ct,
                             input logic [127:0] pt, input int hold);
        int   nr;
        exp_t e;
        nr = 10 + 2 * int'(mode);
        accept(mode, ct);
        sb.push_back('{data: pt, err: (mode == 2'b11)});
        if (mode != 2'b11) begin
            for (int i = 0; i <= nr; i++) begin
                chk("key_idx_seq", 128'(key_idx), 128'(nr - i));
                chk("out_valid_early", 128'(out_valid), 128'd0);
                step();
            end
        end
        chk("out_valid_latency", 128'(out_valid), 128'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 128'd1, 128'(sb.size()));
        end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_err", 128'(out_err), 128'(e.err));
        end
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_out_data", out_data, pt);
            chk("hold_out_valid", 128'(out_valid), 128'd1);
            chk("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = ct;
        in_mode   = 2'b00;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_out_valid", 128'(out_valid), 128'd0);
        chk("release_in_ready", 128'(in_ready), 128'd1);
`ifdef AES_INV_CTRL_BLKCNT_EN
        exp_cnt++;
        chk("blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 128'd0; in_mode = 2'b00;
        step(); step();
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_err", 128'(out_err), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_key_idx", 128'(key_idx), 128'd0);
        rst = 1'b0;
        step();

        run_block(2'b00, CT_128, PT, 5);
        run_block(2'b01, CT_192, PT, 0);
        run_block(2'b10, CT_256, PT, 0);

        run_block(2'b11, CT_128, 128'd0, 0);
        run_block(2'b00, CT_128, PT, 0);

        // Flush at round 4 together with a new offer
        accept(2'b00, CT_128);
        for (int i = 0; i < 4; i++) step();
        chk("flush_round4_key_idx", 128'(key_idx), 128'd6);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = CT_256;
        in_mode  = 2'b10;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_in_ready", 128'(in_ready), 128'd1);
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_key_idx", 128'(key_idx), 128'd0);
        for (int i = 0; i < 14; i++) step();
        chk("flush_no_output", 128'(out_valid), 128'd0);
        run_block(2'b10, CT_256, PT, 0);

        // Reset in the middle of a run, overriding a simultaneous flush
        accept(2'b01, CT_192);
        for (int i = 0; i < 5; i++) step();
        rst   = 1'b1;
        flush = 1'b1;
        step();
        chk("midrun_rst_in_ready", 128'(in_ready), 128'd1);
        chk("midrun_rst_out_valid", 128'(out_valid), 128'd0);
        chk("midrun_rst_out_err", 128'(out_err), 128'd0);
        chk("midrun_rst_out_data", out_data, 128'd0);
        chk("midrun_rst_key_idx", 128'(key_idx), 128'd0);
`ifdef AES_INV_CTRL_BLKCNT_EN
        chk("midrun_rst_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
        rst   = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("midrun_rst_no_output", 128'(out_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_round_ctrl.md
AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port flush, input, 1 bit: synchronous abort of the block in flight.
REQ-004 SHALL have port in_valid, input, 1 bit: ciphertext block offered.
REQ-005 SHALL have port in_ready, output, 1 bit: controller can accept a block.
REQ-006 SHALL have port in_data, input, 128 bits: ciphertext block.
REQ-007 SHALL have port in_mode, input, 2 bits: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
REQ-008 SHALL have port key_idx, output, 4 bits: round-key schedule index requested this cycle.
REQ-009 SHALL have port round_key, input, 128 bits: key for key_idx, valid combinationally in the same cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: plaintext result held.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_data, output, 128 bits: plaintext block.
REQ-013 SHALL have port out_err, output, 1 bit: result came from an illegal-mode block.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL, on in_valid & in_ready, latch in_data into a 128-bit state register, latch in_mode, clear round to 0 and enter RUN.
REQ-016 SHALL set Nr = 10, 12 or 14 for modes 00, 01 and 10 respectively.
REQ-017 SHALL, in RUN, drive one aes_inv_rounddata instance with round, latched mode, round_key and the state register, loading its data_out into the state register each cycle and incrementing round by 1.
REQ-018 SHALL drive key_idx = Nr - round in RUN and 0 otherwise.
REQ-019 SHALL, on the RUN cycle with round == Nr, load data_out into out_data, set out_valid = 1 and enter DONE; latency from the accept edge to out_valid SHALL be Nr+1 cycles (11, 13 or 15).
REQ-020 SHALL hold out_data and out_valid stable in DONE until out_valid & out_ready, then return to IDLE; a new block SHALL NOT be accepted in that same cycle.
REQ-021 SHALL treat an accepted in_mode = 11 block as follows: skip RUN, enter DONE on the next edge with out_data = 0 and out_err = 1.
REQ-022 SHALL clear out_err on every other accepted block.
REQ-023 SHALL use a 4-bit round counter that never exceeds 14 and never wraps.
REQ-024 SHALL, when flush = 1, go to IDLE on the next edge from any state, drop the block in flight and set out_valid = 0; flush SHALL win over a simultaneous in_valid, so no accept occurs.
REQ-025 SHALL ignore in_data and in_mode changes after accept (latched copies only).

Reset
REQ-026 SHALL, while rst = 1 (which overrides flush), enter IDLE and drive in_ready = 1 after the edge, out_valid = 0, out_err = 0, out_data = 0, key_idx = 0, round = 0 and state register = 0.
REQ-027 SHALL, on rst asserted mid-RUN or mid-DONE, abort the block with no output produced.

Configuration
REQ-028 SHALL provide a 32-bit output blk_cnt when AES_INV_CTRL_BLKCNT_EN is defined; blk_cnt resets to 0, increments on each out_valid & out_ready handshake including err blocks, wraps from 0xFFFFFFFF to 0, and is not cleared by flush.
REQ-029 SHALL omit the port and counter when AES_INV_CTRL_BLKCNT_EN is undefined, with all other behaviour identical.

Structure
REQ-030 SHALL take from the shared package aes_pkg: the mode encodings, the NR_128/NR_192/NR_256 constants, the ctrl state enum, and a function mapping mode to Nr.
REQ-031 SHALL contain exactly one sub-module, aes_inv_rounddata; the key schedule stays external.

Verification
REQ-032 SHALL cover FIPS-197 AES-128: key 000102..0f (bench key model), in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid 11 cycles after accept, key_idx sequence 10..0.
REQ-033 SHALL cover AES-192 with key 00..17 and in_data dda97ca4864cdfe06eaf70a0ec0d7191, and AES-256 with key 00..1f and in_data 8ea2b7ca516745bfeafc49904b496089 -> both give 00112233445566778899aabbccddeeff, after 13 and 15 cycles respectively.
REQ-034 SHALL cover out_ready held low 5 cycles -> out_data stable, in_ready = 0 throughout; release -> IDLE, in_ready = 1 on the next cycle.
REQ-035 SHALL cover flush asserted at round 4 together with in_valid = 1 -> no out_valid, IDLE next cycle, no accept that cycle; a following block decrypts correctly.
REQ-036 SHALL cover in_mode = 11 -> out_valid after 1 cycle with out_data = 0 and out_err = 1; the next legal block gives out_err = 0.
REQ-037 SHALL cover rst mid-RUN -> all outputs at reset values; with AES_INV_CTRL_BLKCNT_EN defined, blk_cnt = 3 after three completed blocks and 0 after rst.
